// File: rtl/approx_prod_accum.sv
// approx_prod_accum
//   Streaming accumulator placed after the 8x8 approximate multiplier. It
//   accepts one 16-bit product per valid/ready handshake and adds FRAME_LEN
//   products into an unsigned saturating sum. It then presents the frame
//   result on a valid/ready output and holds it until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_prod carries a product
//   in_ready   block accepts a product this cycle (registered, state only)
//   in_prod    unsigned 16-bit product
//   in_last    (only with APPROX_ACC_LAST_EN) ends the frame early
//   out_valid  frame result valid
//   out_ready  consumer takes the result
//   out_sum    accumulated or saturated frame sum
//   out_count  number of products in the reported frame
//   out_sat    saturation happened at least once in the reported frame
//
// Configuration
//   APPROX_ACC_LAST_EN : when defined, adds in_last after in_prod. An accepted
//   in_last closes the frame early, and out_count reports the real length.
module approx_prod_accum #(
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
`ifdef APPROX_ACC_LAST_EN
  input  logic             in_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             sat_r, sat_s;
  logic             in_ready_r, out_valid_r;
  logic [ACC_W-1:0] out_sum_r;
  logic [CNT_W-1:0] out_count_r;
  logic             out_sat_r;

  logic             accept_s;
  logic             last_s;
  logic             load_s;
  logic [ACC_W:0]   sum_s;
  logic [CNT_W-1:0] cnt_inc_s;

`ifdef APPROX_ACC_LAST_EN
  assign last_s = in_last;
`else
  assign last_s = 1'b0;
`endif

  // in_ready_r is high only in ACCUM, so no accept can happen while a result is held.
  assign accept_s  = in_valid && in_ready_r;
  // One extra bit catches the carry that signals overflow.
  assign sum_s     = {1'b0, acc_r} + {{(ACC_W-15){1'b0}}, in_prod};
  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state, accumulator update and result-load decision
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    sat_s   = sat_r;
    load_s  = 1'b0;
    case (state_r)
      ACCUM: begin
        if (accept_s) begin
          cnt_s = cnt_inc_s;
          if (sum_s[ACC_W]) begin
            acc_s = {ACC_W{1'b1}};
            sat_s = 1'b1;
          end else begin
            acc_s = sum_s[ACC_W-1:0];
            sat_s = sat_r;
          end
          if ((cnt_inc_s == FRAME_CNT) || last_s) begin
            state_s = HOLD;
            load_s  = 1'b1;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = ACCUM;
          acc_s   = {ACC_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          sat_s   = 1'b0;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = ACCUM;
        acc_s   = {ACC_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
        sat_s   = 1'b0;
      end
    endcase
  end

  // State, accumulator, handshake flags and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ACCUM;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sat_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_sum_r   <= {ACC_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      out_sat_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      sat_r       <= sat_s;
      in_ready_r  <= (state_s == ACCUM);
      out_valid_r <= (state_s == HOLD);
      // The load captures the values that already include the closing accept.
      if (load_s) begin
        out_sum_r   <= acc_s;
        out_count_r <= cnt_s;
        out_sat_r   <= sat_s;
      end else begin
        out_sum_r   <= out_sum_r;
        out_count_r <= out_count_r;
        out_sat_r   <= out_sat_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_count = out_count_r;
  assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_approx_prod_accum.sv
// Self-checking bench for approx_prod_accum. It runs two instances in
// lockstep: the default 24-bit accumulator and a 17-bit one that saturates.
module tb_approx_prod_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_sat;
  logic [23:0] out_sum;
  logic [7:0]  out_count;
  logic        in_ready17, out_valid17, out_sat17;
  logic [16:0] out_sum17;
  logic [7:0]  out_count17;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  approx_prod_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod),
`ifdef APPROX_ACC_LAST_EN
    .in_last(in_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_sat(out_sat)
  );

  approx_prod_accum #(.ACC_W(17)) dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready17),
    .in_prod(in_prod),
`ifdef APPROX_ACC_LAST_EN
    .in_last(in_last),
`endif
    .out_valid(out_valid17), .out_ready(out_ready), .out_sum(out_sum17),
    .out_count(out_count17), .out_sat(out_sat17)
  );

  typedef struct {
    string       name;
    logic [15:0] base;
    logic        incr;      // products are 1..16 instead of a constant
    logic        gaps;      // insert (k % 3) bubbles before accept k
    int          hold;      // cycles out_ready stays low while the result is held
    logic [23:0] exp_sum;
    logic        exp_sat;
    logic [16:0] exp_sum17;
    logic        exp_sat17;
  } frame_t;

  frame_t vec[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_one(input logic [15:0] v, input logic last);
    in_valid = 1'b1;
    in_prod  = v;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Runs one 16-product frame, checks the result, holds it, then releases it.
  task automatic run_frame(input frame_t f);
    logic [15:0] v;
    logic [24:0] gold;
    gold = 25'd0;
    for (int k = 0; k < 16; k++) begin
      if (f.gaps) begin
        repeat (k % 3) tick();
      end
      v = f.incr ? 16'(k + 1) : f.base;
      gold = gold + {9'd0, v};
      chk({f.name, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
      accept_one(v, 1'b0);
      if (k == 14) chk({f.name, " out_valid early"}, {31'd0, out_valid}, 32'd0);
    end
    chk({f.name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({f.name, " in_ready in hold"}, {31'd0, in_ready}, 32'd0);
    chk({f.name, " out_sum"}, {8'd0, out_sum}, {8'd0, f.exp_sum});
    chk({f.name, " golden sum"}, {7'd0, gold}, {8'd0, f.exp_sum});
    chk({f.name, " out_count"}, {24'd0, out_count}, 32'd16);
    chk({f.name, " out_sat"}, {31'd0, out_sat}, {31'd0, f.exp_sat});
    chk({f.name, " out_valid17"}, {31'd0, out_valid17}, 32'd1);
    chk({f.name, " out_sum17"}, {15'd0, out_sum17}, {15'd0, f.exp_sum17});
    chk({f.name, " out_sat17"}, {31'd0, out_sat17}, {31'd0, f.exp_sat17});
    out_ready = 1'b0;
    for (int h = 0; h < f.hold; h++) begin
      tick();
      chk({f.name, " hold valid"}, {31'd0, out_valid}, 32'd1);
      chk({f.name, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({f.name, " hold sum"}, {8'd0, out_sum}, {8'd0, f.exp_sum});
      chk({f.name, " hold count"}, {24'd0, out_count}, 32'd16);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({f.name, " released valid"}, {31'd0, out_valid}, 32'd0);
    chk({f.name, " released in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    frame_t f2;
    vec[0] = '{"t1_100",   16'd100,    1'b0, 1'b0, 0, 24'd1600,    1'b0, 17'd1600,    1'b0};
    vec[1] = '{"t2_hold",  16'd100,    1'b0, 1'b0, 5, 24'd1600,    1'b0, 17'd1600,    1'b0};
    vec[2] = '{"t3_ffff",  16'hFFFF,   1'b0, 1'b0, 1, 24'h0FFFF0,  1'b0, 17'h1FFFF,   1'b1};
    vec[3] = '{"t3_zero",  16'd0,      1'b0, 1'b0, 0, 24'd0,       1'b0, 17'd0,       1'b0};
    vec[4] = '{"t4_gaps",  16'd0,      1'b1, 1'b1, 2, 24'd136,     1'b0, 17'd136,     1'b0};

    rst = 1'b1; in_valid = 1'b0; in_prod = 16'd0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_sum", {8'd0, out_sum}, 32'd0);
    chk("reset out_count", {24'd0, out_count}, 32'd0);
    chk("reset out_sat", {31'd0, out_sat}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_frame(vec[i]);

    // Reset after 7 accepts discards the partial frame and the old result.
    for (int k = 0; k < 7; k++) accept_one(16'd5, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5 out_valid after rst", {31'd0, out_valid}, 32'd0);
    chk("t5 out_sum after rst", {8'd0, out_sum}, 32'd0);
    repeat (3) tick();
    chk("t5 no result emitted", {31'd0, out_valid}, 32'd0);
    f2 = '{"t5_twos", 16'd2, 1'b0, 1'b0, 1, 24'd32, 1'b0, 17'd32, 1'b0};
    run_frame(f2);

`ifdef APPROX_ACC_LAST_EN
    for (int k = 0; k < 5; k++) begin
      accept_one(16'd10, (k == 4));
      if (k == 3) chk("t6 out_valid early", {31'd0, out_valid}, 32'd0);
    end
    chk("t6 out_valid", {31'd0, out_valid}, 32'd1);
    chk("t6 out_sum", {8'd0, out_sum}, 32'd50);
    chk("t6 out_count", {24'd0, out_count}, 32'd5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6 released", {31'd0, in_ready}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
